// File: rtl/gtxe2_common_drp_master.sv
// gtxe2_common_drp_master
// DRP initiator for a GTXE2_COMMON quad PLL tile. It takes one read or write
// command at a time and pulses DRPEN/DRPWE for that command. It waits for
// DRPRDY up to TIMEOUT_CYCLES cycles and returns read data or a timeout flag.
//
// Optional build macro: GTXE2_DRP_MASTER_RMW_EN
//   When defined, a write with CMD_MASK != 16'hFFFF is done as a read followed
//   by a masked write. RSP_DATA then returns the value read before the write.
//
// Parameter:
//   TIMEOUT_CYCLES    : cycles waited for DRPRDY after a strobe (2..65535)
// Ports:
//   DRPCLK, RESET     : clock, synchronous active-high reset
//   CMD_VALID/READY   : command handshake
//   CMD_WE, CMD_ADDR, CMD_DATA, CMD_MASK : command payload
//   RSP_VALID/READY   : response handshake
//   RSP_DATA, RSP_TIMEOUT : response payload
//   DRPADDR, DRPDI, DRPEN, DRPWE : strobes to the responder
//   DRPDO, DRPRDY     : data and ready from the responder
module gtxe2_common_drp_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        DRPCLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WE,
  input  logic [7:0]  CMD_ADDR,
  input  logic [15:0] CMD_DATA,
  input  logic [15:0] CMD_MASK,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic        RSP_TIMEOUT,
  output logic [7:0]  DRPADDR,
  output logic [15:0] DRPDI,
  output logic        DRPEN,
  output logic        DRPWE,
  input  logic [15:0] DRPDO,
  input  logic        DRPRDY
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cmd_ready_n, rsp_valid_n, rsp_timeout_n, drp_en_n, drp_we_n;
  logic [15:0]      rsp_data_n, drp_di_n;
  logic [7:0]       drp_addr_n;
  logic             accept_c;

  assign accept_c = CMD_VALID && CMD_READY;

`ifdef GTXE2_DRP_MASTER_RMW_EN
  logic        rmw_q, rmw_n;
  logic [15:0] data_q, data_n;
  logic [15:0] mask_q, mask_n;
  logic [15:0] rd_data_q, rd_data_n;
  logic        rmw_hit_c;
  logic [15:0] wr_merge_c;

  assign rmw_hit_c  = CMD_WE && (CMD_MASK != 16'hFFFF);
  // Patch only the masked bits into the value just read back.
  assign wr_merge_c = (DRPDO & ~mask_q) | (data_q & mask_q);
`else
  logic unused_mask;
  assign unused_mask = ^CMD_MASK;
`endif

  // State and registered outputs.
  always_ff @(posedge DRPCLK) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      CMD_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_DATA    <= '0;
      RSP_TIMEOUT <= 1'b0;
      DRPADDR     <= '0;
      DRPDI       <= '0;
      DRPEN       <= 1'b0;
      DRPWE       <= 1'b0;
`ifdef GTXE2_DRP_MASTER_RMW_EN
      rmw_q       <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      rd_data_q   <= '0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      CMD_READY   <= cmd_ready_n;
      RSP_VALID   <= rsp_valid_n;
      RSP_DATA    <= rsp_data_n;
      RSP_TIMEOUT <= rsp_timeout_n;
      DRPADDR     <= drp_addr_n;
      DRPDI       <= drp_di_n;
      DRPEN       <= drp_en_n;
      DRPWE       <= drp_we_n;
`ifdef GTXE2_DRP_MASTER_RMW_EN
      rmw_q       <= rmw_n;
      data_q      <= data_n;
      mask_q      <= mask_n;
      rd_data_q   <= rd_data_n;
`endif
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    rsp_valid_n   = RSP_VALID;
    rsp_data_n    = RSP_DATA;
    rsp_timeout_n = RSP_TIMEOUT;
    drp_addr_n    = DRPADDR;
    drp_di_n      = DRPDI;
`ifdef GTXE2_DRP_MASTER_RMW_EN
    rmw_n         = rmw_q;
    data_n        = data_q;
    mask_n        = mask_q;
    rd_data_n     = rd_data_q;
`endif

    case (state)
      IDLE: begin
        if (accept_c) begin
          drp_addr_n = CMD_ADDR;
`ifdef GTXE2_DRP_MASTER_RMW_EN
          rmw_n  = rmw_hit_c;
          data_n = CMD_DATA;
          mask_n = CMD_MASK;
          if (!CMD_WE || rmw_hit_c) begin
            state_n = RD_REQ;
          end else begin
            state_n  = WR_REQ;
            drp_di_n = CMD_DATA;
          end
`else
          if (CMD_WE) begin
            state_n  = WR_REQ;
            drp_di_n = CMD_DATA;
          end else begin
            state_n = RD_REQ;
          end
`endif
        end
      end

      RD_REQ: begin
        state_n = RD_WAIT;
        cnt_n   = '0;
      end

      // DRPRDY is checked before the counter so it wins on the last cycle.
      RD_WAIT: begin
        if (DRPRDY) begin
`ifdef GTXE2_DRP_MASTER_RMW_EN
          if (rmw_q) begin
            rd_data_n = DRPDO;
            drp_di_n  = wr_merge_c;
            state_n   = WR_REQ;
          end else begin
            state_n       = RESP;
            rsp_valid_n   = 1'b1;
            rsp_data_n    = DRPDO;
            rsp_timeout_n = 1'b0;
          end
`else
          state_n       = RESP;
          rsp_valid_n   = 1'b1;
          rsp_data_n    = DRPDO;
          rsp_timeout_n = 1'b0;
`endif
        end else if (cnt == CNT_LAST) begin
          state_n       = RESP;
          rsp_valid_n   = 1'b1;
          rsp_data_n    = '0;
          rsp_timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      WR_REQ: begin
        state_n = WR_WAIT;
        cnt_n   = '0;
      end

      WR_WAIT: begin
        if (DRPRDY) begin
          state_n       = RESP;
          rsp_valid_n   = 1'b1;
          rsp_timeout_n = 1'b0;
`ifdef GTXE2_DRP_MASTER_RMW_EN
          rsp_data_n    = rmw_q ? rd_data_q : 16'h0000;
`else
          rsp_data_n    = '0;
`endif
        end else if (cnt == CNT_LAST) begin
          state_n       = RESP;
          rsp_valid_n   = 1'b1;
          rsp_data_n    = '0;
          rsp_timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RESP: begin
        if (RSP_READY) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Strobes exist only in the REQ states, so each lasts exactly one cycle.
    drp_en_n    = (state_n == RD_REQ) || (state_n == WR_REQ);
    drp_we_n    = (state_n == WR_REQ);
    cmd_ready_n = (state_n == IDLE);
  end

endmodule
